// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: pixel divider, sync timing and four frame-latched patterns.
// Optional macro VGA_PATTERN_BORDER_EN forces a one-pixel all-ones border around the visible area.
module vga_pattern_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned CNT_W     = 11,
    parameter int unsigned RGB_W     = 12,
    parameter int unsigned CHK_LOG2  = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [RGB_W-1:0] sw,
    input  logic [1:0]       mode,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             frame_start,
    output logic [RGB_W-1:0] rgb
);

    localparam int unsigned H_TOTAL      = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_DISPLAY + H_FP;
    localparam int unsigned H_SYNC_END   = H_DISPLAY + H_FP + H_SYNC;
    localparam int unsigned V_SYNC_START = V_DISPLAY + V_FP;
    localparam int unsigned V_SYNC_END   = V_DISPLAY + V_FP + V_SYNC;
    localparam int unsigned DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned THIRD        = RGB_W / 3;
    localparam int unsigned BAR_W        = H_DISPLAY / 8;

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [RGB_W-1:0] sw_q;
    logic [1:0]       mode_q;
    logic             wrap_pend;
    logic             out_en;
    logic             p_tick;
    logic             h_end;
    logic             v_end;
    logic             frame_end;

    assign p_tick    = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign h_end     = (h_cnt == CNT_W'(H_TOTAL - 1));
    assign v_end     = (v_cnt == CNT_W'(V_TOTAL - 1));
    assign frame_end = p_tick && h_end && v_end;

    // Pixel divider, raster counters and frame-boundary input latch.
    // out_en holds the outputs at reset values for the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt   <= '0;
            h_cnt     <= '0;
            v_cnt     <= '0;
            sw_q      <= '0;
            mode_q    <= '0;
            wrap_pend <= 1'b0;
            out_en    <= 1'b0;
        end else begin
            div_cnt <= p_tick ? '0 : div_cnt + DIV_W'(1);
            if (p_tick) begin
                h_cnt <= h_end ? '0 : h_cnt + CNT_W'(1);
                if (h_end) begin
                    v_cnt <= v_end ? '0 : v_cnt + CNT_W'(1);
                end
            end
            if (frame_end) begin
                sw_q   <= sw;
                mode_q <= mode;
            end
            wrap_pend <= frame_end;
            out_en    <= 1'b1;
        end
    end

    logic             hsync_c;
    logic             vsync_c;
    logic             video_c;
    logic [2:0]       bar_idx;
    logic [RGB_W-1:0] pat;
    logic [RGB_W-1:0] rgb_c;

    // Sync/visible decode and pattern colour of the current counters.
    always_comb begin
        hsync_c = !((h_cnt >= CNT_W'(H_SYNC_START)) && (h_cnt < CNT_W'(H_SYNC_END)));
        vsync_c = !((v_cnt >= CNT_W'(V_SYNC_START)) && (v_cnt < CNT_W'(V_SYNC_END)));
        video_c = (h_cnt < CNT_W'(H_DISPLAY)) && (v_cnt < CNT_W'(V_DISPLAY));

        bar_idx = '0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (h_cnt >= CNT_W'(k * BAR_W)) begin
                bar_idx = 3'(k);
            end
        end

        case (mode_q)
            2'd0:    pat = sw_q;
            2'd1:    pat = {{THIRD{bar_idx[2]}}, {THIRD{bar_idx[1]}}, {THIRD{bar_idx[0]}}};
            2'd2:    pat = (h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]) ? ~sw_q : sw_q;
            default: pat = ((h_cnt[CHK_LOG2-1:0] == '0) || (v_cnt[CHK_LOG2-1:0] == '0)) ? '1 : '0;
        endcase

`ifdef VGA_PATTERN_BORDER_EN
        if ((h_cnt == '0) || (h_cnt == CNT_W'(H_DISPLAY - 1)) ||
            (v_cnt == '0) || (v_cnt == CNT_W'(V_DISPLAY - 1))) begin
            pat = '1;
        end
`endif

        rgb_c = video_c ? pat : '0;
    end

    // Output registers, updated every clk one cycle behind the counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_start <= 1'b0;
            rgb         <= '0;
        end else if (out_en) begin
            hsync       <= hsync_c;
            vsync       <= vsync_c;
            video_on    <= video_c;
            pixel_x     <= h_cnt;
            pixel_y     <= v_cnt;
            frame_start <= wrap_pend;
            rgb         <= rgb_c;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomized self-checking bench for vga_pattern_gen on a small timing mode,
// compared against an arithmetic raster model (honours VGA_PATTERN_BORDER_EN).
module tb_vga_pattern_gen;

    localparam int HD = 16, HF = 2, HS = 3, HB = 3;
    localparam int VD = 8, VF = 1, VS = 2, VB = 1;
    localparam int CD = 2, CW = 11, RW = 12, CL = 2;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FRAME = HT * VT * CD;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [RW-1:0] sw;
    logic [1:0]    mode;
    logic          hsync, vsync, video_on, frame_start;
    logic [CW-1:0] pixel_x, pixel_y;
    logic [RW-1:0] rgb;

    vga_pattern_gen #(
        .H_DISPLAY(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_DISPLAY(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(CD), .CNT_W(CW), .RGB_W(RW), .CHK_LOG2(CL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sw(sw), .mode(mode),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .frame_start(frame_start), .rgb(rgb)
    );

    always #5 clk = ~clk;

    int            vectors = 0;
    int            miscompares = 0;
    int            n = 0;
    logic [RW-1:0] lat_sw = '0;
    logic [1:0]    lat_mode = '0;
    int            cur_x = -1, cur_y = -1;
    int            hs_low = 0, vs_low = 0, fs_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected colour of raster position (x,y) from the pattern rules.
    function automatic logic [RW-1:0] ref_rgb(input int x, input int y,
                                              input logic [RW-1:0] s, input logic [1:0] m);
        int t;
        int third;
        int i;
        int acc;
        t = RW / 3;
        third = (1 << t) - 1;
        if (!(x < HD && y < VD)) return '0;
`ifdef VGA_PATTERN_BORDER_EN
        if (x == 0 || x == HD - 1 || y == 0 || y == VD - 1) return '1;
`endif
        case (m)
            2'd0: return s;
            2'd1: begin
                i = x / (HD / 8);
                if (i > 7) i = 7;
                acc = 0;
                if ((i & 4) != 0) acc = acc | (third << (2 * t));
                if ((i & 2) != 0) acc = acc | (third << t);
                if ((i & 1) != 0) acc = acc | third;
                return RW'(acc);
            end
            2'd2: return ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? ~s : s;
            default: return ((x % (1 << CL)) == 0 || (y % (1 << CL)) == 0) ? '1 : '0;
        endcase
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_hsync"}, 32'(hsync), 32'd1);
        check({tag, "_vsync"}, 32'(vsync), 32'd1);
        check({tag, "_video_on"}, 32'(video_on), 32'd0);
        check({tag, "_pixel_x"}, 32'(pixel_x), 32'd0);
        check({tag, "_pixel_y"}, 32'(pixel_y), 32'd0);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        check({tag, "_rgb"}, 32'(rgb), 32'd0);
    endtask

    // One clk: model the outputs from the raster position reached one edge earlier.
    task automatic step();
        int s, ticks, h, v;
        logic e_hs, e_vs, e_von, e_fs;
        int ex, ey;
        logic [RW-1:0] e_rgb;
        @(posedge clk);
        n++;
        s = n - 1;
        ticks = s / CD;
        h = ticks % HT;
        v = (ticks / HT) % VT;
        if (n == 1) begin
            e_hs = 1'b1; e_vs = 1'b1; e_von = 1'b0; e_fs = 1'b0;
            ex = 0; ey = 0; e_rgb = '0;
        end else begin
            e_hs  = !(h >= HD + HF && h < HD + HF + HS);
            e_vs  = !(v >= VD + VF && v < VD + VF + VS);
            e_von = (h < HD) && (v < VD);
            e_fs  = (s % CD == 0) && (ticks % (HT * VT) == 0);
            ex = h; ey = v;
            e_rgb = ref_rgb(h, v, lat_sw, lat_mode);
        end
        if (s % CD == CD - 1 && h == HT - 1 && v == VT - 1) begin
            lat_sw = sw;
            lat_mode = mode;
        end
        #1;
        cur_x = (n == 1) ? -1 : ex;
        cur_y = (n == 1) ? -1 : ey;
        check("hsync", 32'(hsync), 32'(e_hs));
        check("vsync", 32'(vsync), 32'(e_vs));
        check("video_on", 32'(video_on), 32'(e_von));
        check("pixel_x", 32'(pixel_x), 32'(ex));
        check("pixel_y", 32'(pixel_y), 32'(ey));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("rgb", 32'(rgb), 32'(e_rgb));
        if (!hsync) hs_low++;
        if (!vsync) vs_low++;
        if (frame_start) fs_cnt++;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic release_reset();
        reset_n = 1'b1;
        n = 0;
        lat_sw = '0;
        lat_mode = '0;
    endtask

    initial begin
        logic found;
        sw = '0;
        mode = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        release_reset();

        run(100);
        sw = 12'hA5C;
        mode = 2'd0;
        run(2 * FRAME);

        hs_low = 0; vs_low = 0; fs_cnt = 0;
        run(FRAME);
        check("hsync_low_clks_per_frame", 32'(hs_low), 32'(12 * 6));
        check("vsync_low_clks_per_frame", 32'(vs_low), 32'(96));
        check("frame_starts_per_frame", 32'(fs_cnt), 32'd1);

        mode = 2'd1;
        run(FRAME + 37);
        mode = 2'd2;
        sw = 12'h123;
        run(FRAME + 211);
        mode = 2'd3;
        run(FRAME + 5);
        run(FRAME);

        for (int i = 0; i < 6 * FRAME; i++) begin
            step();
            if ($urandom_range(0, 99) == 0) begin
                sw = RW'($urandom);
                mode = 2'($urandom);
            end
        end

        mode = 2'd2;
        sw = RW'($urandom);
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            step();
            found = (cur_x == 10 && cur_y == 3);
        end
        check("reach_pixel_10_3", 32'(found), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset("async_rst");
        @(posedge clk);
        #1;
        check_reset("held_rst");
        release_reset();
        run(2 * FRAME + 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
